// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running counter: classifies each sample as a
// good step, wrap, restart or error, keeps saturating statistics, and posts
// wrap/error/restart events through a one-entry valid/ready buffer.
// Ports: clk, rstn (async, active-low), clr (sync clear), in_vld/cnt_in
//   (sample in), wrap_pulse/err_pulse (1-cycle pulses), state (0 IDLE,
//   1 TRACK, 2 RESYNC), wrap_cnt/err_cnt (saturating), evt_valid/evt_ready/
//   evt_data {type,value} (event out), evt_ovf (sticky drop flag).
module count_seq_checker #(
    parameter int WIDTH  = 4,
    parameter int STATW  = 8,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [1:0]       state,
    output logic [STATW-1:0] wrap_cnt,
    output logic [STATW-1:0] err_cnt,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH+1:0] evt_data,
    output logic             evt_ovf
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_RESYNC = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LP_MAX  = {WIDTH{1'b1}};
    localparam logic [STATW-1:0] LP_S1   = {{(STATW-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LP_SYNC = 4'(SYNC_N);

    localparam logic [1:0] T_WRAP = 2'b01;
    localparam logic [1:0] T_ERR  = 2'b10;
    localparam logic [1:0] T_RST  = 2'b11;

    state_t             r_state;
    logic [WIDTH-1:0]   r_prev;
    logic [3:0]         r_run;
    logic               r_wrap_p;
    logic               r_err_p;
    logic [STATW-1:0]   r_wrap_cnt;
    logic [STATW-1:0]   r_err_cnt;
    logic               r_evt_valid;
    logic [WIDTH+1:0]   r_evt_data;
    logic               r_evt_ovf;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_prev_nxt;
    logic [3:0]         w_run_nxt;
    logic               w_wrap;
    logic               w_err;
    logic [STATW-1:0]   w_wcnt_nxt;
    logic [STATW-1:0]   w_ecnt_nxt;
    logic               w_ev_new;
    logic [WIDTH+1:0]   w_ev_dat;
    logic               w_valid_nxt;
    logic [WIDTH+1:0]   w_data_nxt;
    logic               w_ovf_nxt;
    logic [WIDTH-1:0]   w_exp;
    logic [3:0]         w_run_inc;
    logic               w_xfer;

    assign w_exp     = r_prev + LP_ONE;
    assign w_run_inc = r_run + 4'd1;
    assign w_xfer    = r_evt_valid & evt_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_run_nxt   = r_run;
        w_wrap      = 1'b0;
        w_err       = 1'b0;
        w_wcnt_nxt  = r_wrap_cnt;
        w_ecnt_nxt  = r_err_cnt;
        w_ev_new    = 1'b0;
        w_ev_dat    = '0;
        w_valid_nxt = r_evt_valid;
        w_data_nxt  = r_evt_data;
        w_ovf_nxt   = r_evt_ovf;

        if (in_vld) begin
            w_prev_nxt = cnt_in;
            unique case (r_state)
                S_IDLE: w_state_nxt = S_TRACK;
                S_TRACK: begin
                    if (cnt_in == w_exp) begin
                        // Only a wrap among good steps is reported
                        if (r_prev == LP_MAX) begin
                            w_wrap   = 1'b1;
                            w_ev_new = 1'b1;
                            w_ev_dat = {T_WRAP, cnt_in};
                        end
                    end else if (cnt_in == '0) begin
                        // Upstream restarted: report the value it left at
                        w_ev_new = 1'b1;
                        w_ev_dat = {T_RST, r_prev};
                    end else begin
                        w_err       = 1'b1;
                        w_ev_new    = 1'b1;
                        w_ev_dat    = {T_ERR, cnt_in};
                        w_state_nxt = S_RESYNC;
                        w_run_nxt   = '0;
                    end
                end
                S_RESYNC: begin
                    if (cnt_in == w_exp) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == LP_SYNC)
                            w_state_nxt = S_TRACK;
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_wrap && r_wrap_cnt != '1)
            w_wcnt_nxt = r_wrap_cnt + LP_S1;
        if (w_err && r_err_cnt != '1)
            w_ecnt_nxt = r_err_cnt + LP_S1;

        // A slot freed by this cycle's transfer can take the new event
        if (w_xfer)
            w_valid_nxt = 1'b0;
        if (w_ev_new) begin
            if (!r_evt_valid || w_xfer) begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_ev_dat;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end

        if (clr) begin
            w_state_nxt = S_IDLE;
            w_prev_nxt  = '0;
            w_run_nxt   = '0;
            w_wrap      = 1'b0;
            w_err       = 1'b0;
            w_wcnt_nxt  = '0;
            w_ecnt_nxt  = '0;
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_ovf_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_run       <= '0;
            r_wrap_p    <= 1'b0;
            r_err_p     <= 1'b0;
            r_wrap_cnt  <= '0;
            r_err_cnt   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_data  <= '0;
            r_evt_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_run       <= w_run_nxt;
            r_wrap_p    <= w_wrap;
            r_err_p     <= w_err;
            r_wrap_cnt  <= w_wcnt_nxt;
            r_err_cnt   <= w_ecnt_nxt;
            r_evt_valid <= w_valid_nxt;
            r_evt_data  <= w_data_nxt;
            r_evt_ovf   <= w_ovf_nxt;
        end
    end

    assign wrap_pulse = r_wrap_p;
    assign err_pulse  = r_err_p;
    assign state      = r_state;
    assign wrap_cnt   = r_wrap_cnt;
    assign err_cnt    = r_err_cnt;
    assign evt_valid  = r_evt_valid;
    assign evt_data   = r_evt_data;
    assign evt_ovf    = r_evt_ovf;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus randomized
// stimulus checked every cycle against a behavioural model.
module tb_count_seq_checker;

    localparam int SN = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clr = 1'b0;
    logic       in_vld = 1'b0;
    logic [3:0] cnt_in = '0;
    logic       evt_ready = 1'b0;
    logic       wrap_pulse, err_pulse, evt_valid, evt_ovf;
    logic [1:0] state;
    logic [7:0] wrap_cnt, err_cnt;
    logic [5:0] evt_data;

    count_seq_checker #(.WIDTH(4), .STATW(8), .SYNC_N(SN)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .in_vld     (in_vld),
        .cnt_in     (cnt_in),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .state      (state),
        .wrap_cnt   (wrap_cnt),
        .err_cnt    (err_cnt),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_ovf    (evt_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: mode 0 idle, 1 tracking, 2 resyncing
    int m_mode, m_prev, m_run, m_wc, m_ec;
    int m_wp, m_ep, m_ev, m_ed, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_prev = 0; m_run = 0; m_wc = 0; m_ec = 0;
        m_wp = 0; m_ep = 0; m_ev = 0; m_ed = 0; m_ovf = 0;
    endtask

    task automatic m_step(input int v, input int val, input int r,
                          input int c);
        int ev;
        int nxt;
        if (c != 0) begin
            m_reset();
            return;
        end
        ev = -1;
        m_wp = 0;
        m_ep = 0;
        if (m_ev != 0 && r != 0) m_ev = 0;
        if (v != 0) begin
            nxt = (m_prev + 1) % 16;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (val == nxt) begin
                    if (m_prev == 15) begin
                        m_wp = 1;
                        if (m_wc < 255) m_wc++;
                        ev = 16 + val;
                    end
                end else if (val == 0) begin
                    ev = 48 + m_prev;
                end else begin
                    m_ep = 1;
                    if (m_ec < 255) m_ec++;
                    ev = 32 + val;
                    m_mode = 2;
                    m_run = 0;
                end
            end else begin
                if (val == nxt) begin
                    m_run++;
                    if (m_run == SN) m_mode = 1;
                end else begin
                    m_run = 0;
                end
            end
            m_prev = val;
        end
        if (ev >= 0) begin
            if (m_ev == 0) begin
                m_ev = 1;
                m_ed = ev;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic cmp_all();
        chk("wrap_pulse", 32'(wrap_pulse), m_wp);
        chk("err_pulse", 32'(err_pulse), m_ep);
        chk("state", 32'(state), m_mode);
        chk("wrap_cnt", 32'(wrap_cnt), m_wc);
        chk("err_cnt", 32'(err_cnt), m_ec);
        chk("evt_valid", 32'(evt_valid), m_ev);
        chk("evt_data", 32'(evt_data), m_ed);
        chk("evt_ovf", 32'(evt_ovf), m_ovf);
    endtask

    task automatic cyc(input int v, input int val, input int r,
                       input int c);
        in_vld    = (v != 0);
        cnt_in    = 4'(val);
        evt_ready = (r != 0);
        clr       = (c != 0);
        @(posedge clk);
        m_step(v, val, r, c);
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        in_vld = 1'b0;
        clr = 1'b0;
        evt_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cmp_all();
    endtask

    initial begin
        int v, val, r, c, pick;
        m_reset();

        do_reset();
        chk("rst_state", 32'(state), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);

        // Full count then wrap back to 0
        for (int i = 0; i < 16; i++) cyc(1, i, 1, 0);
        cyc(1, 0, 1, 0);
        chk("wrap_pulse_d", 32'(wrap_pulse), 1);
        chk("wrap_cnt_d", 32'(wrap_cnt), 1);
        chk("wrap_evt_d", 32'(evt_data), 32'h10);
        chk("wrap_errcnt_d", 32'(err_cnt), 0);
        cyc(0, 0, 1, 0);
        chk("wrap_pulse_1cyc", 32'(wrap_pulse), 0);

        // Error then resync after two good steps
        do_reset();
        cyc(1, 4, 1, 0);
        cyc(1, 5, 1, 0);
        cyc(1, 9, 1, 0);
        chk("err_pulse_d", 32'(err_pulse), 1);
        chk("err_cnt_d", 32'(err_cnt), 1);
        chk("err_evt_d", 32'(evt_data), 32'h29);
        chk("err_state_d", 32'(state), 2);
        cyc(1, 10, 1, 0);
        chk("resync_mid", 32'(state), 2);
        cyc(1, 11, 1, 0);
        chk("resync_done", 32'(state), 1);
        cyc(1, 12, 1, 0);
        chk("resync_no_err", 32'(err_pulse), 0);

        // Upstream restart is not an error
        do_reset();
        cyc(1, 6, 1, 0);
        cyc(1, 7, 1, 0);
        cyc(1, 0, 1, 0);
        chk("rst_evt_pulse", 32'(err_pulse), 0);
        chk("rst_evt_data", 32'(evt_data), 32'h37);
        chk("rst_evt_state", 32'(state), 1);
        cyc(1, 1, 1, 0);
        chk("rst_evt_state2", 32'(state), 1);

        // Backpressure: second event dropped
        do_reset();
        cyc(1, 15, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 3, 0, 0);
        chk("bp_data", 32'(evt_data), 32'h10);
        chk("bp_valid", 32'(evt_valid), 1);
        chk("bp_ovf", 32'(evt_ovf), 1);
        chk("bp_errcnt", 32'(err_cnt), 1);

        // Asynchronous reset with an event buffered
        @(negedge clk);
        rstn = 1'b0;
        #1;
        m_reset();
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_data", 32'(evt_data), 0);
        chk("arst_ovf", 32'(evt_ovf), 0);
        chk("arst_errcnt", 32'(err_cnt), 0);
        chk("arst_wrapcnt", 32'(wrap_cnt), 0);
        chk("arst_state", 32'(state), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(0, 0, 0, 0);
        chk("arst_rel_state", 32'(state), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) < 8) ? 1 : 0;
            pick = $urandom_range(0, 9);
            if (pick < 6) val = (m_prev + 1) % 16;
            else if (pick < 8) val = 0;
            else val = $urandom_range(0, 15);
            r = ($urandom_range(0, 9) < 6) ? 1 : 0;
            c = ($urandom_range(0, 199) == 0) ? 1 : 0;
            cyc(v, val, r, c);
        end

        // Statistics saturation then clear
        do_reset();
        for (int w = 0; w < 300; w++)
            for (int i = 0; i < 16; i++) cyc(1, i, 0, 0);
        cyc(1, 0, 0, 0);
        chk("sat_wrap_cnt", 32'(wrap_cnt), 255);
        chk("sat_ovf", 32'(evt_ovf), 1);
        cyc(0, 0, 0, 1);
        chk("clr_wrap_cnt", 32'(wrap_cnt), 0);
        chk("clr_state", 32'(state), 0);
        chk("clr_ovf", 32'(evt_ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream monitor for the free-running 4-bit counter stage.
- Samples the counter output and checks that each sample is the previous one plus 1, modulo 2^WIDTH.
- Classifies each transition as a good step, a wrap, a restart or an error, and keeps saturating statistics.
- Reports wrap/error/restart events through a one-entry valid/ready event buffer to a logger downstream.

Parameters:
- WIDTH, 4: width of the monitored count.
- STATW, 8: width of the saturating wrap and error statistics counters.
- SYNC_N, 2: consecutive good steps in RESYNC needed to return to TRACK; legal range 1..15.

Ports:
- clk  input  1  clock; all flops on its rising edge.
- rstn  input  1  reset, asynchronous, active-low; clears all state and outputs.
- clr  input  1  synchronous clear; same effect as reset; priority over all other inputs.
- in_vld  input  1  cnt_in is a sample this cycle.
- cnt_in  input  WIDTH  monitored count value.
- wrap_pulse  output  1  one-cycle pulse: wrap detected.
- err_pulse  output  1  one-cycle pulse: sequence error detected.
- state  output  2  0=IDLE, 1=TRACK, 2=RESYNC.
- wrap_cnt  output  STATW  saturating wrap count.
- err_cnt  output  STATW  saturating error count.
- evt_valid  output  1  event buffer holds an event.
- evt_ready  input  1  consumer accepts the event.
- evt_data  output  WIDTH+2  {type[1:0], value[WIDTH-1:0]}; type 01=wrap, 10=error, 11=restart.
- evt_ovf  output  1  sticky flag: an event was dropped.

Behaviour:
- Reset values (rstn low, or clr high at a clock edge):
  - state=IDLE.
  - prev=0.
  - wrap_cnt, err_cnt, the good-step run counter, wrap_pulse, err_pulse, evt_valid, evt_ovf = 0.
  - evt_data=0.
- Reset is asynchronous. Asserting it mid-operation discards any buffered event immediately.
- Samples are taken only when in_vld=1. Cycles with in_vld=0 change nothing except the pulses, which return to 0, and the event handshake.
- Timing: all outputs are registered. A sample at edge N produces its pulses, statistics update and event at edge N+1. Pulses last exactly one cycle.
- Each sample updates prev to cnt_in. exp = prev+1 mod 2^WIDTH.
- IDLE:
  - First sample stores prev and moves to TRACK.
  - No pulses and no events.
- TRACK:
  - cnt_in==exp and prev==2^WIDTH-1 (so cnt_in==0): wrap. Assert wrap_pulse, increment wrap_cnt, post event type 01 with value=cnt_in.
  - cnt_in==exp otherwise: good step. No action.
  - cnt_in==0 and not exp: restart (upstream reset). Post event type 11 with value=prev. Stay in TRACK. Not an error.
  - Any other value: error. Assert err_pulse, increment err_cnt, post event type 10 with value=cnt_in. Go to RESYNC with run=0.
- RESYNC:
  - cnt_in==exp: run increments. When run reaches SYNC_N, go to TRACK.
  - Mismatch: run=0. No further err_pulse, err_cnt increment or event.
  - A wrap inside RESYNC counts as a good step only. No wrap_pulse.
- Statistics: wrap_cnt and err_cnt saturate at 2^STATW-1 and never roll over.
- Event buffer (one entry):
  - A transfer completes when evt_valid and evt_ready are both 1 at a clock edge.
  - On a new event, the event is loaded (evt_valid=1) if the buffer is empty or a transfer completes in that same cycle.
  - Otherwise the new event is dropped and evt_ovf is set.
  - evt_data is held stable while evt_valid=1 and evt_ready=0.
  - evt_ovf clears only on reset or clr.
- At most one event is generated per sample.

Test Plan:
- Reset: rstn low mid-stream with evt_valid=1 → all outputs 0 immediately, before the next clk edge. state=0 after release.
- Wrap: samples 0..15 then 0, evt_ready=1 → one wrap_pulse the cycle after the final 0. wrap_cnt=1; evt_data=6'b01_0000; err_cnt=0.
- Error and resync, SYNC_N=2: samples 4,5,9,10,11,12 → err_pulse after the 9. err_cnt=1; evt_data=6'b10_1001; state=2. state returns to 1 after sample 11.
- Restart: samples 6,7,0,1 → no err_pulse. evt_data=6'b11_0111; state stays 1.
- Backpressure: evt_ready=0, samples 15,0,3 → first event (01_0000) is held. Error event is dropped and evt_ovf=1. err_cnt=1 still.
- Saturation and clear: 300 wraps → wrap_cnt=255. Then clr=1 for one cycle → wrap_cnt=0, state=0, evt_ovf=0.
